pdp11_insn_encoder: RTL and testbench

- Sequential instruction encoder: the write side of the simulator's instruction decode formats (double-op, branch, single-op, PSW, jump, swab, system).
- Accepts one symbolic instruction (mnemonic index, addressing modes, registers, branch offset, extension words) through a valid/ready handshake.
- Emits the 16-bit machine-code stream as 1 to 3 words: opcode word, then source extension word, then destination extension word, each with valid/ready.
- Feeds the memory-image loader and the encode/decode round-trip checks.

---
 rtl/pdp11_insn_encoder.sv | 225 ++++++++++++++++++++++
 tb/tb_pdp11_insn_encoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pdp11_insn_encoder.sv
// PDP-11 instruction encoder: symbolic request in, 1-3 machine words out.
// Optional request checks are compiled in with PDP11_ENC_CHECK_EN.
module pdp11_insn_encoder #(
   parameter int WORD_SIZE = 16,
   parameter int MNEM_W    = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MNEM_W-1:0]    in_mnem,
   input  logic [2:0]           in_smod,
   input  logic [2:0]           in_sreg,
   input  logic [2:0]           in_dmod,
   input  logic [2:0]           in_dreg,
   input  logic [7:0]           in_ofst,
   input  logic [WORD_SIZE-1:0] in_src_ext,
   input  logic [WORD_SIZE-1:0] in_dst_ext,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_word,
   output logic [1:0]           out_kind,
   output logic                 out_last,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, OP, SRC, DST} state_t;

   state_t                 state_q, state_d;
   logic [WORD_SIZE-1:0]   opword_q, opword_d;
   logic [WORD_SIZE-1:0]   sext_q, sext_d;
   logic [WORD_SIZE-1:0]   dext_q, dext_d;
   logic                   nsrc_q, nsrc_d;
   logic                   ndst_q, ndst_d;
   logic                   err_q, err_d;

   logic [15:0] enc;
   logic [5:0]  ss, dd;
   logic [2:0]  n3;
   logic [4:0]  idx;
   logic        use_src, use_dst, jmp_like, known, reject;
   logic        need_src, need_dst;

   function automatic logic ext_needed(input logic [2:0] md,
                                       input logic [2:0] rg);
      return (md == 3'd6) || (md == 3'd7) ||
             ((rg == 3'd7) && ((md == 3'd2) || (md == 3'd3)));
   endfunction

   // Opcode word and operand usage for the request on the input port
   always_comb begin
      enc      = '0;
      use_src  = 1'b0;
      use_dst  = 1'b0;
      jmp_like = 1'b0;
      known    = 1'b1;
      ss       = {in_smod, in_sreg};
      dd       = {in_dmod, in_dreg};
      n3       = in_mnem[3:1] + 3'd1;
      idx      = 5'(in_mnem - 7'd29);
      if (in_mnem <= 7'd9) begin
         enc     = {in_mnem[0], n3, ss, dd};
         use_src = 1'b1;
         use_dst = 1'b1;
      end else if (in_mnem <= 7'd11) begin
         enc     = {in_mnem[0], 3'b110, ss, dd};
         use_src = 1'b1;
         use_dst = 1'b1;
      end else if (in_mnem <= 7'd26) begin
         case (in_mnem)
            7'd12:   enc = 16'o000400;
            7'd13:   enc = 16'o001000;
            7'd14:   enc = 16'o001400;
            7'd15:   enc = 16'o002000;
            7'd16:   enc = 16'o002400;
            7'd17:   enc = 16'o003000;
            7'd18:   enc = 16'o003400;
            7'd19:   enc = 16'o100000;
            7'd20:   enc = 16'o100400;
            7'd21:   enc = 16'o101000;
            7'd22:   enc = 16'o101400;
            7'd23:   enc = 16'o102000;
            7'd24:   enc = 16'o102400;
            7'd25:   enc = 16'o103000;
            default: enc = 16'o103400;
         endcase
         enc = enc | {8'd0, in_ofst};
      end else if (in_mnem == 7'd27) begin
         enc      = 16'o004000 | {7'd0, in_sreg, dd};
         use_dst  = 1'b1;
         jmp_like = 1'b1;
      end else if (in_mnem == 7'd28) begin
         enc = 16'o000200 | {13'd0, in_sreg};
      end else if (in_mnem <= 7'd52) begin
         enc = (16'o005000 + {6'd0, idx[4:1], 6'd0})
             | {idx[0], 9'd0, dd};
         use_dst = 1'b1;
      end else if (in_mnem == 7'd53) begin
         enc      = 16'o000100 | {10'd0, dd};
         use_dst  = 1'b1;
         jmp_like = 1'b1;
      end else if (in_mnem == 7'd54) begin
         enc     = 16'o000300 | {10'd0, dd};
         use_dst = 1'b1;
      end else if (in_mnem <= 7'd64) begin
         case (in_mnem)
            7'd55:   enc = 16'o000000;
            7'd56:   enc = 16'o000240;
            7'd57:   enc = 16'o000241;
            7'd58:   enc = 16'o000242;
            7'd59:   enc = 16'o000244;
            7'd60:   enc = 16'o000250;
            7'd61:   enc = 16'o000261;
            7'd62:   enc = 16'o000262;
            7'd63:   enc = 16'o000264;
            default: enc = 16'o000270;
         endcase
      end else begin
         known = 1'b0;
      end
      need_src = use_src && ext_needed(in_smod, in_sreg);
      need_dst = use_dst && ext_needed(in_dmod, in_dreg);
`ifdef PDP11_ENC_CHECK_EN
      reject = !known
             || (jmp_like && (in_dmod == 3'd0))
             || (use_src && (ss == 6'o77) && (in_src_ext == '0))
             || (use_dst && (dd == 6'o77) && (in_dst_ext == '0));
`else
      reject = !known || (jmp_like && 1'b0);
`endif
   end

   // Next-state: accept in IDLE, then walk OP/SRC/DST on each handshake
   always_comb begin
      state_d  = state_q;
      opword_d = opword_q;
      sext_d   = sext_q;
      dext_d   = dext_q;
      nsrc_d   = nsrc_q;
      ndst_d   = ndst_q;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (reject) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = OP;
                  opword_d = WORD_SIZE'(enc);
                  sext_d   = in_src_ext;
                  dext_d   = in_dst_ext;
                  nsrc_d   = need_src;
                  ndst_d   = need_dst;
               end
            end
         end
         OP: begin
            if (out_ready) begin
               if (nsrc_q)      state_d = SRC;
               else if (ndst_q) state_d = DST;
               else             state_d = IDLE;
            end
         end
         SRC: begin
            if (out_ready) state_d = ndst_q ? DST : IDLE;
         end
         default: begin
            if (out_ready) state_d = IDLE;
         end
      endcase
   end

   // State and latched request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         opword_q <= '0;
         sext_q   <= '0;
         dext_q   <= '0;
         nsrc_q   <= 1'b0;
         ndst_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opword_q <= opword_d;
         sext_q   <= sext_d;
         dext_q   <= dext_d;
         nsrc_q   <= nsrc_d;
         ndst_q   <= ndst_d;
         err_q    <= err_d;
      end
   end

   // Output word selection; stable while stalled since state holds
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_word  = '0;
      out_kind  = 2'd0;
      out_last  = 1'b0;
      unique case (state_q)
         IDLE: in_ready = 1'b1;
         OP: begin
            out_valid = 1'b1;
            out_word  = opword_q;
            out_last  = !nsrc_q && !ndst_q;
         end
         SRC: begin
            out_valid = 1'b1;
            out_word  = sext_q;
            out_kind  = 2'd1;
            out_last  = !ndst_q;
         end
         default: begin
            out_valid = 1'b1;
            out_word  = dext_q;
            out_kind  = 2'd2;
            out_last  = 1'b1;
         end
      endcase
   end

   assign err = err_q;

endmodule

// File: tb/tb_pdp11_insn_encoder.sv
// Directed bench for pdp11_insn_encoder.
// Expected words are hand-encoded octal constants.
module tb_pdp11_insn_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_mnem;
   logic [2:0]  in_smod, in_sreg, in_dmod, in_dreg;
   logic [7:0]  in_ofst;
   logic [15:0] in_src_ext, in_dst_ext;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_word;
   logic [1:0]  out_kind;
   logic        out_last;
   logic        err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pdp11_insn_encoder dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mnem(in_mnem), .in_smod(in_smod), .in_sreg(in_sreg),
      .in_dmod(in_dmod), .in_dreg(in_dreg), .in_ofst(in_ofst),
      .in_src_ext(in_src_ext), .in_dst_ext(in_dst_ext),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_kind(out_kind),
      .out_last(out_last), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expw(input string tag, input logic [15:0] w,
                       input logic [1:0] k, input logic l);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".word"}, 32'(out_word), 32'(w));
      chk({tag, ".kind"}, 32'(out_kind), 32'(k));
      chk({tag, ".last"}, 32'(out_last), 32'(l));
   endtask

   task automatic req(input logic [6:0] m, input logic [2:0] sm,
                      input logic [2:0] sr, input logic [2:0] dm,
                      input logic [2:0] dr, input logic [7:0] of,
                      input logic [15:0] se, input logic [15:0] de);
      in_mnem    = m;
      in_smod    = sm;
      in_sreg    = sr;
      in_dmod    = dm;
      in_dreg    = dr;
      in_ofst    = of;
      in_src_ext = se;
      in_dst_ext = de;
      in_valid   = 1'b1;
      step();
      in_valid   = 1'b0;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      in_mnem = '0; in_smod = '0; in_sreg = '0;
      in_dmod = '0; in_dreg = '0; in_ofst = '0;
      in_src_ext = '0; in_dst_ext = '0;
      step();
      step();
      reset = 1'b0;
      idle_chk("rst");
      chk("rst.word", 32'(out_word), 32'd0);
      chk("rst.kind", 32'(out_kind), 32'd0);
      chk("rst.last", 32'(out_last), 32'd0);
      chk("rst.err", 32'(err), 32'd0);

      // MOV R1,R2
      req(7'd0, 3'd0, 3'd1, 3'd0, 3'd2, 8'd0, 16'd0, 16'd0);
      expw("mov", 16'o010102, 2'd0, 1'b1);
      chk("mov.in_ready", 32'(in_ready), 32'd0);
      step();
      idle_chk("mov.done");

      // ADD #5,6(R3) with a 3-cycle stall on the opcode word
      out_ready = 1'b0;
      req(7'd10, 3'd2, 3'd7, 3'd6, 3'd3, 8'd0, 16'd5, 16'd6);
      for (int i = 0; i < 3; i++) begin
         expw("add.stall", 16'o062763, 2'd0, 1'b0);
         if (i < 2) step();
      end
      out_ready = 1'b1;
      step();
      expw("add.src", 16'o000005, 2'd1, 1'b0);
      step();
      expw("add.dst", 16'o000006, 2'd2, 1'b1);
      step();
      idle_chk("add.done");

      // BNE .-2
      req(7'd13, 3'd0, 3'd0, 3'd0, 3'd0, 8'hFE, 16'd0, 16'd0);
      expw("bne", 16'o001376, 2'd0, 1'b1);
      step();

      // SEN and HALT
      req(7'd64, 3'd5, 3'd5, 3'd5, 3'd5, 8'hFF, 16'hFFFF, 16'hFFFF);
      expw("sen", 16'o000270, 2'd0, 1'b1);
      step();
      req(7'd55, 3'd7, 3'd7, 3'd7, 3'd7, 8'hFF, 16'd1, 16'd1);
      expw("halt", 16'o000000, 2'd0, 1'b1);
      step();

      // CLRB R3, ASL R0, SUB R4,R5
      req(7'd30, 3'd0, 3'd0, 3'd0, 3'd3, 8'd0, 16'd0, 16'd0);
      expw("clrb", 16'o105003, 2'd0, 1'b1);
      step();
      req(7'd51, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0);
      expw("asl", 16'o006300, 2'd0, 1'b1);
      step();
      req(7'd11, 3'd0, 3'd4, 3'd0, 3'd5, 8'd0, 16'd0, 16'd0);
      expw("sub", 16'o160405, 2'd0, 1'b1);
      step();

      // JSR PC,@#1000 ; RTS PC
      req(7'd27, 3'd0, 3'd7, 3'd3, 3'd7, 8'd0, 16'd9, 16'o001000);
      expw("jsr", 16'o004737, 2'd0, 1'b0);
      step();
      expw("jsr.dst", 16'o001000, 2'd2, 1'b1);
      step();
      req(7'd28, 3'd3, 3'd7, 3'd6, 3'd1, 8'd0, 16'd0, 16'd0);
      expw("rts", 16'o000207, 2'd0, 1'b1);
      step();

      // SWAB 4(R1)
      req(7'd54, 3'd6, 3'd2, 3'd6, 3'd1, 8'd0, 16'd7, 16'd4);
      expw("swab", 16'o000361, 2'd0, 1'b0);
      step();
      expw("swab.dst", 16'o000004, 2'd2, 1'b1);
      step();
      idle_chk("swab.done");

      // Unknown mnemonic, then MOV back-to-back
      req(7'd100, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0);
      chk("bad.err", 32'(err), 32'd1);
      idle_chk("bad");
      req(7'd0, 3'd0, 3'd1, 3'd0, 3'd2, 8'd0, 16'd0, 16'd0);
      chk("bad.err_gone", 32'(err), 32'd0);
      expw("b2b.mov", 16'o010102, 2'd0, 1'b1);
      step();

      // Reset while the ADD source extension waits
      req(7'd10, 3'd2, 3'd7, 3'd6, 3'd3, 8'd0, 16'd5, 16'd6);
      out_ready = 1'b0;
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      expw("rst_mid.src", 16'o000005, 2'd1, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      idle_chk("rst_mid");
      chk("rst_mid.word", 32'(out_word), 32'd0);

      // JMP R0
      req(7'd53, 3'd0, 3'd0, 3'd0, 3'd0, 8'd0, 16'd0, 16'd0);
`ifdef PDP11_ENC_CHECK_EN
      chk("jmp.err", 32'(err), 32'd1);
      idle_chk("jmp");
`else
      chk("jmp.err", 32'(err), 32'd0);
      expw("jmp", 16'o000100, 2'd0, 1'b1);
`endif
      step();
      idle_chk("end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
